keypad_scan: RTL and testbench
==============================

Name: keypad_scan

Overview:
- Input-side counterpart of the multiplexed seven-segment display driver.
- Scans a 4x4 active-low matrix keypad one column at a time and debounces over whole scan frames.
- Emits a one-cycle key event carrying a 4-bit key code, plus a held level.
- Sits between the board keypad pins and the text/menu logic that feeds the display.

Parameters:
- SCAN_DIV, 100000: clock cycles each column is driven before its rows are sampled; minimum 4.
- DEBOUNCE_FRAMES, 3: consecutive identical full frames required to accept a press, and to accept a release; minimum 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- row_in  in  4  keypad rows, active-low, asynchronous to clk
- col_out  out  4  column drive, active-low, exactly one bit low at all times
- key_code  out  4  code of last accepted key = col*4 + row
- key_valid  out  1  one-cycle pulse on accepted press
- key_held  out  1  high from accepted press until accepted release
- multi_key  out  1  high for the frame after a frame that saw two or more keys

Behaviour:
- Reset (synchronous, active-high) sets:
  - col_out=4'b1110 (column 0), tick counter=0, frame accumulator cleared.
  - row synchroniser=4'b1111, state=IDLE.
  - key_code=0, key_valid=0, key_held=0, multi_key=0.
- Row synchroniser: row_in passes through a 2-FF synchroniser; all sampling uses the synchronised value.
- Tick and column scan:
  - Counter runs 0..SCAN_DIV-1, then wraps to 0.
  - On the cycle where counter==SCAN_DIV-1 (the tick), the current column's rows are sampled.
  - On that same edge the column advances 0->1->2->3->0; col_out is the column index one-hot inverted (col 1 = 4'b1101).
- Frame evaluation:
  - A frame is the 4 ticks for columns 0..3.
  - Frame-end is the tick of column 3; the first frame-end occurs at cycle 4*SCAN_DIV-1 after reset release.
  - Frame result: number of pressed (low) row bits summed over all columns, and the code of the first pressed key.
  - Search order is column ascending, then row ascending (row index = bit position).
- FSM, updated only on the frame-end edge:
  - IDLE, exactly one key: go to DEBOUNCE with cand=code, cnt=1. If DEBOUNCE_FRAMES==1, go directly to PRESSED and accept.
  - IDLE, zero keys or two or more keys: stay in IDLE.
  - DEBOUNCE, same single key: cnt+1. When cnt reaches DEBOUNCE_FRAMES, go to PRESSED and accept.
  - DEBOUNCE, different key, no key, or multi-key: go to IDLE, cnt=0.
  - PRESSED, zero keys: go to RELEASE, cnt=1. If DEBOUNCE_FRAMES==1, go to IDLE and release.
  - PRESSED, any key(s) present: stay. No new event; key_code is unchanged.
  - RELEASE, zero keys: cnt+1. When cnt reaches DEBOUNCE_FRAMES, go to IDLE and release.
  - RELEASE, any key present: go back to PRESSED, cnt=0. No new event.
- Accept: key_code<=cand and key_held<=1 on the frame-end edge. key_valid is high for exactly the one cycle after that edge.
- Release: key_held<=0 on the frame-end edge. key_code keeps its last value.
- multi_key: registered on every frame-end, high iff that frame counted two or more keys.
- Latency: a clean press stable from a frame start gives key_valid one cycle after frame-end number DEBOUNCE_FRAMES.
- Boundary conditions:
  - A key appearing mid-frame counts only for columns sampled after it appears; a partial first frame may read as empty.
  - Counters saturate at DEBOUNCE_FRAMES.
  - Reset mid-debounce or mid-hold clears everything; no key_valid is issued for the interrupted press.

Test Plan (SCAN_DIV=4, DEBOUNCE_FRAMES=3, frame=16 cycles; the bench models the keypad by driving row_in[r]=0 while col_out[c]==0 for each pressed (c,r)):
- Reset, no keys -> col_out cycles 1110,1101,1011,0111 each held 4 cycles; key_valid, key_held, multi_key stay 0 for 10 frames.
- Press (c=2,r=1) from frame start -> exactly one key_valid pulse one cycle after the 3rd frame-end; key_code=9; key_held=1.
- Release after hold -> key_held falls at the 3rd empty frame-end; no key_valid; key_code stays 9.
- Bounce: (c=0,r=3) present on alternate frames for 10 frames -> no key_valid; key_held=0.
- Press (1,0) and (3,2) together -> multi_key=1 after each frame, no key_valid.
- While (1,0) is held, add (3,2) -> no second pulse, key_code stays 4.
- Reset mid-debounce: (3,3) held 2 frames, assert rst 1 cycle -> all outputs 0, col_out=1110. Keep (3,3) held: key_valid occurs 3 full frames after reset, with key_code=15.

Source files
------------

// File: rtl/keypad_scan.sv
// 4x4 active-low matrix keypad scanner: one column driven at a time, rows
// synchronised and sampled once per column, press/release debounced over frames.
module keypad_scan #(
  parameter int unsigned SCAN_DIV        = 100000,
  parameter int unsigned DEBOUNCE_FRAMES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       multi_key
);
  localparam int unsigned   TW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned   CW        = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_PRESSED, S_RELEASE} state_e;

  logic [3:0]    row_meta_q, row_sync_q;
  logic [TW-1:0] tick_q;
  logic [1:0]    col_q;
  logic [1:0]    acc_cnt_q;
  logic          acc_found_q;
  logic [3:0]    acc_code_q;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_held_q, key_held_d;
  logic          multi_q, multi_d;

  logic          tick, frame_end;
  logic [3:0]    pressed;
  logic [2:0]    col_keys, cnt_sum;
  logic [1:0]    frame_cnt;
  logic          frame_found;
  logic [3:0]    frame_code;
  logic [1:0]    row_idx;
  logic [CW-1:0] cnt_inc;
  logic          single_key, no_key;

  // Running frame result including the column being sampled on this tick.
  always_comb begin
    tick      = (tick_q == TICK_LAST);
    frame_end = tick && (col_q == 2'd3);
    pressed   = ~row_sync_q;
    col_keys  = 3'(pressed[0]) + 3'(pressed[1]) + 3'(pressed[2]) + 3'(pressed[3]);
    // Column 0 opens a new frame, so the stored totals are ignored there.
    cnt_sum   = (col_q == 2'd0) ? col_keys : ({1'b0, acc_cnt_q} + col_keys);
    frame_cnt = (cnt_sum >= 3'd2) ? 2'd2 : cnt_sum[1:0];

    row_idx = 2'd0;
    if (pressed[0])      row_idx = 2'd0;
    else if (pressed[1]) row_idx = 2'd1;
    else if (pressed[2]) row_idx = 2'd2;
    else if (pressed[3]) row_idx = 2'd3;

    frame_found = (col_q != 2'd0) && acc_found_q;
    frame_code  = acc_code_q;
    if (!frame_found && (pressed != 4'd0)) begin
      frame_found = 1'b1;
      frame_code  = {col_q, row_idx};
    end

    single_key = (frame_cnt == 2'd1);
    no_key     = (frame_cnt == 2'd0);
    cnt_inc    = (cnt_q >= CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  end

  always_comb begin
    // NOTE: every output of this block gets a default before any branch, so
    // no path leaves a signal unassigned and no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    key_code_d  = key_code_q;
    key_held_d  = key_held_q;
    key_valid_d = 1'b0;
    multi_d     = multi_q;

    if (frame_end) begin
      multi_d = (frame_cnt == 2'd2);
      unique case (state_q)
        S_IDLE: begin
          if (single_key) begin
            cand_d = frame_code;
            if (DEBOUNCE_FRAMES == 1) begin
              state_d     = S_PRESSED;
              cnt_d       = '0;
              key_code_d  = frame_code;
              key_held_d  = 1'b1;
              key_valid_d = 1'b1;
            end else begin
              state_d = S_DEBOUNCE;
              cnt_d   = CW'(1);
            end
          end
        end
        S_DEBOUNCE: begin
          if (single_key && (frame_code == cand_q)) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              state_d     = S_PRESSED;
              cnt_d       = '0;
              key_code_d  = cand_q;
              key_held_d  = 1'b1;
              key_valid_d = 1'b1;
            end
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
        S_PRESSED: begin
          if (no_key) begin
            if (DEBOUNCE_FRAMES == 1) begin
              state_d    = S_IDLE;
              cnt_d      = '0;
              key_held_d = 1'b0;
            end else begin
              state_d = S_RELEASE;
              cnt_d   = CW'(1);
            end
          end
        end
        S_RELEASE: begin
          if (no_key) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              state_d    = S_IDLE;
              cnt_d      = '0;
              key_held_d = 1'b0;
            end
          end else begin
            state_d = S_PRESSED;
            cnt_d   = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta_q  <= 4'hF;
      row_sync_q  <= 4'hF;
      tick_q      <= '0;
      col_q       <= 2'd0;
      acc_cnt_q   <= 2'd0;
      acc_found_q <= 1'b0;
      acc_code_q  <= 4'd0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cand_q      <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      multi_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every register sample the
      // pre-edge value of the others, which the synchroniser chain relies on.
      row_meta_q  <= row_in;
      row_sync_q  <= row_meta_q;
      tick_q      <= tick ? '0 : tick_q + 1'b1;
      if (tick) begin
        col_q       <= col_q + 2'd1;
        acc_cnt_q   <= frame_cnt;
        acc_found_q <= frame_found;
        acc_code_q  <= frame_code;
      end
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      multi_q     <= multi_d;
    end
  end

  assign col_out   = ~(4'b0001 << col_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign multi_key = multi_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a keypad model drives rows from the column strobes; a
// frame-level reference model predicts every output on every cycle.
module tb_keypad_scan;
  localparam int SD = 4;
  localparam int DF = 3;
  localparam int FL = 4 * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] keys = '0;   // bit c*4+r set = key (c,r) pressed
  logic [3:0]  row_in, col_out, key_code;
  logic        key_valid, key_held, multi_key;

  keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
    .clk      (clk),
    .rst      (rst),
    .row_in   (row_in),
    .col_out  (col_out),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held),
    .multi_key(multi_key)
  );

  always #5 clk = ~clk;

  // Matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int c = 0; c < 4; c++)
      if (col_out[c] === 1'b0) row_in = row_in & ~keys[4*c +: 4];
  end

  int checks = 0;
  int failures = 0;
  int valid_count = 0;
  int last_valid_cyc = -1;

  // Reference model state
  int          cyc = 0;
  bit          live = 1'b0;
  logic [15:0] hist [FL];
  int          run = 0;
  logic [3:0]  cand = '0;
  logic        exp_valid = 1'b0, exp_held = 1'b0, exp_multi = 1'b0;
  logic [3:0]  exp_code = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Each column's rows are read at its last cycle through a 2-cycle
  // synchroniser, i.e. they reflect the keypad SD-3 cycles into that column.
  task automatic model_step();
    int         cnt;
    bit         found;
    logic [3:0] code;
    logic [3:0] rows;
    if (rst) begin
      cyc = 0; live = 1'b1; run = 0; cand = '0;
      exp_valid = 1'b0; exp_held = 1'b0; exp_multi = 1'b0; exp_code = '0;
      return;
    end
    exp_valid = 1'b0;
    hist[cyc % FL] = keys;
    if (cyc % FL == FL - 1) begin
      cnt = 0; found = 1'b0; code = '0;
      for (int c = 0; c < 4; c++) begin
        rows = hist[c*SD + SD - 3][4*c +: 4];
        for (int r = 0; r < 4; r++)
          if (rows[r]) begin
            cnt++;
            if (!found) begin found = 1'b1; code = 4'(4*c + r); end
          end
      end
      exp_multi = (cnt >= 2);
      if (!exp_held) begin
        if (cnt == 1) begin
          if (run == 0) begin run = 1; cand = code; end
          else if (code == cand) run++;
          else run = 0;
          if (run >= DF) begin
            exp_held = 1'b1; exp_valid = 1'b1; exp_code = cand; run = 0;
          end
        end else run = 0;
      end else begin
        if (cnt == 0) begin
          run++;
          if (run >= DF) begin exp_held = 1'b0; run = 0; end
        end else run = 0;
      end
    end
    cyc++;
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    logic [3:0] ec;
    if (live) begin
      ec = ~(4'b0001 << ((cyc / SD) % 4));
      check("col_out", col_out, ec);
      check("key_valid", key_valid, exp_valid);
      check("key_held", key_held, exp_held);
      check("key_code", key_code, exp_code);
      check("multi_key", multi_key, exp_multi);
      if (key_valid === 1'b1) begin
        valid_count    <= valid_count + 1;
        last_valid_cyc <= cyc;
      end
    end
  end

  task automatic run_to(input int n);
    int guard = 0;
    while (cyc != n && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) check("run_to_timeout", cyc, n);
  endtask

  task automatic next_frame();
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (cyc % FL != FL - 1 && guard < 200);
    if (cyc % FL != FL - 1) check("frame_timeout", cyc % FL, FL - 1);
  endtask

  task automatic apply_reset(input logic [15:0] k);
    @(negedge clk);
    rst = 1'b1;
    keys = k;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int v0;
    int kind, dur, a, b;
    logic [15:0] m;

    // Idle scan after reset
    apply_reset(16'h0000);
    check("rst_col", col_out, 4'b1110);
    check("rst_valid", key_valid, 1'b0);
    check("rst_held", key_held, 1'b0);
    check("rst_code", key_code, 4'd0);
    check("rst_multi", multi_key, 1'b0);
    v0 = valid_count;
    run_to(5);
    check("col1_lit", col_out, 4'b1101);
    run_to(10);
    check("col2_lit", col_out, 4'b1011);
    run_to(10 * FL);
    check("idle_no_valid", valid_count - v0, 0);

    // Clean press of (2,1) from a frame start
    v0 = valid_count;
    apply_reset(16'h0200);
    run_to(49);
    check("press_pulses", valid_count - v0, 1);
    check("press_latency", last_valid_cyc, 48);
    check("press_code", key_code, 4'd9);
    check("press_held", key_held, 1'b1);

    // Release after hold
    run_to(63);
    keys = 16'h0000;
    run_to(111);
    check("rel_held_before", key_held, 1'b1);
    run_to(112);
    check("rel_held_after", key_held, 1'b0);
    check("rel_code", key_code, 4'd9);
    check("rel_no_valid", valid_count - v0, 1);

    // Bounce of (0,3) on alternate frames
    v0 = valid_count;
    for (int i = 0; i < 10; i++) begin
      next_frame();
      keys = (i % 2 == 0) ? 16'h0008 : 16'h0000;
    end
    next_frame();
    @(negedge clk);
    check("bounce_no_valid", valid_count - v0, 0);
    check("bounce_held", key_held, 1'b0);

    // Two keys together
    next_frame();
    keys = 16'h4010;
    for (int i = 0; i < 3; i++) begin
      next_frame();
      @(negedge clk);
      check("multi_frame", multi_key, 1'b1);
    end
    check("multi_no_valid", valid_count - v0, 0);

    // Hold (1,0), then add (3,2)
    next_frame();
    keys = 16'h0010;
    repeat (4) next_frame();
    @(negedge clk);
    check("hold4_pulse", valid_count - v0, 1);
    check("hold4_code", key_code, 4'd4);
    keys = 16'h4010;
    repeat (3) next_frame();
    @(negedge clk);
    check("add_no_pulse", valid_count - v0, 1);
    check("add_code", key_code, 4'd4);
    check("add_held", key_held, 1'b1);
    check("add_multi", multi_key, 1'b1);

    // Reset in the middle of debouncing (3,3)
    keys = 16'h0000;
    repeat (5) next_frame();
    check("pre_rst_held", key_held, 1'b0);
    next_frame();
    keys = 16'h8000;
    repeat (2) next_frame();
    @(negedge clk);
    v0 = valid_count;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_col", col_out, 4'b1110);
    check("mid_rst_valid", key_valid, 1'b0);
    check("mid_rst_held", key_held, 1'b0);
    check("mid_rst_code", key_code, 4'd0);
    check("mid_rst_multi", multi_key, 1'b0);
    run_to(49);
    check("post_rst_pulses", valid_count - v0, 1);
    check("post_rst_latency", last_valid_cyc, 48);
    check("post_rst_code", key_code, 4'd15);

    // Random key patterns, durations, phases and occasional resets
    for (int s = 0; s < 60; s++) begin
      kind = $urandom_range(0, 5);
      dur  = $urandom_range(1, 6);
      case (kind)
        0:       m = 16'h0000;
        1, 2, 3: m = 16'h0001 << $urandom_range(0, 15);
        4: begin
          a = $urandom_range(0, 15);
          b = (a + $urandom_range(1, 15)) % 16;
          m = (16'h0001 << a) | (16'h0001 << b);
        end
        default: m = 16'($urandom());
      endcase
      repeat ($urandom_range(0, FL - 1)) @(negedge clk);
      if ($urandom_range(0, 24) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      keys = m;
      repeat (dur * FL) @(negedge clk);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
